// File: rtl/ddr3_cmd_issue_if.sv
// Channel-request and controller-command signals for ddr3_cmd_issue.
// The master modport is the issuing block; the slave modport is its environment
// (the arbitration tree on the request side and the DDR3 controller app port).
interface ddr3_cmd_issue_if;
  // Request side, from the arbitration compare tree
  logic        i_ch_req;
  logic [4:0]  i_ch_num;
  logic [15:0] i_ch_priority;
  logic        i_ch_rd_wrn;
  logic [26:0] i_ch_start_addr;
  logic [11:0] i_ch_length;
  logic [31:0] o_ch_ack;
  logic        o_busy;
  // Controller application command port
  logic        o_app_en;
  logic [2:0]  o_app_cmd;
  logic [26:0] o_app_addr;
  logic        i_app_rdy;
  // Completion report
  logic        o_done;
  logic [4:0]  o_done_num;
  // Priority of the transfer in flight, for observation only
  logic [15:0] o_cur_priority;

  modport master (
    input  i_ch_req, i_ch_num, i_ch_priority, i_ch_rd_wrn, i_ch_start_addr,
           i_ch_length, i_app_rdy,
    output o_ch_ack, o_busy, o_app_en, o_app_cmd, o_app_addr, o_done,
           o_done_num, o_cur_priority
  );

  modport slave (
    output i_ch_req, i_ch_num, i_ch_priority, i_ch_rd_wrn, i_ch_start_addr,
           i_ch_length, i_app_rdy,
    input  o_ch_ack, o_busy, o_app_en, o_app_cmd, o_app_addr, o_done,
           o_done_num, o_cur_priority
  );
endinterface

// File: rtl/ddr3_cmd_issue.sv
// DDR3 command issuer: accepts one arbitrated channel request, acknowledges it,
// issues one controller command per 8-word burst, reports completion, and then
// holds off new requests for P_HOLDOFF cycles.
module ddr3_cmd_issue #(
  parameter int unsigned P_HOLDOFF = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  ddr3_cmd_issue_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACK,
    ST_CMD,
    ST_DONE,
    ST_HOLD
  } state_t;

  // Last value of the holdoff counter before returning to IDLE
  localparam logic [3:0] HOLD_LAST = (P_HOLDOFF == 0) ? 4'd0 : 4'(P_HOLDOFF - 1);

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  state_t      state_q, state_d;
  logic [4:0]  num_q, num_d;
  logic [15:0] prio_q, prio_d;
  logic        rd_wrn_q, rd_wrn_d;
  logic [26:0] addr_q, addr_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [3:0]  hold_q, hold_d;

  // State and captured-command registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      num_q    <= '0;
      prio_q   <= '0;
      rd_wrn_q <= 1'b0;
      addr_q   <= '0;
      cnt_q    <= '0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      num_q    <= num_d;
      prio_q   <= prio_d;
      rd_wrn_q <= rd_wrn_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
    end
  end

  // Next-state logic and state-decoded outputs
  always_comb begin
    state_d  = state_q;
    num_d    = num_q;
    prio_d   = prio_q;
    rd_wrn_d = rd_wrn_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    hold_d   = hold_q;

    bus.o_ch_ack   = '0;
    bus.o_busy     = (state_q != ST_IDLE);
    bus.o_app_en   = 1'b0;
    bus.o_app_cmd  = CMD_WRITE;
    bus.o_app_addr = '0;
    bus.o_done     = 1'b0;
    bus.o_done_num = '0;

    case (state_q)
      ST_IDLE: begin
        if (bus.i_ch_req) begin
          num_d    = bus.i_ch_num;
          prio_d   = bus.i_ch_priority;
          rd_wrn_d = bus.i_ch_rd_wrn;
          addr_d   = bus.i_ch_start_addr;
          // Round the word count up to whole 8-word bursts (4095 -> 512)
          cnt_d    = 10'(({1'b0, bus.i_ch_length} + 13'd7) >> 3);
          state_d  = ST_ACK;
        end
      end

      ST_ACK: begin
        bus.o_ch_ack = 32'd1 << num_q;
        state_d      = (cnt_q == 10'd0) ? ST_DONE : ST_CMD;
      end

      ST_CMD: begin
        bus.o_app_en   = 1'b1;
        bus.o_app_cmd  = rd_wrn_q ? CMD_READ : CMD_WRITE;
        bus.o_app_addr = addr_q;
        // Command, address and enable simply stay put while the controller stalls
        if (bus.i_app_rdy) begin
          cnt_d  = cnt_q - 10'd1;
          addr_d = addr_q + 27'd8;
          if (cnt_q == 10'd1) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        bus.o_done     = 1'b1;
        bus.o_done_num = num_q;
        hold_d         = '0;
        state_d        = (P_HOLDOFF == 0) ? ST_IDLE : ST_HOLD;
      end

      ST_HOLD: begin
        if (hold_q == HOLD_LAST) begin
          state_d = ST_IDLE;
        end else begin
          hold_d = hold_q + 4'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.o_cur_priority = prio_q;

endmodule

// File: tb/tb_ddr3_cmd_issue.sv
// Directed bench for ddr3_cmd_issue: a vector table of single transfers plus
// hand-written sequences for re-request during holdoff and reset mid-transfer.
module tb_ddr3_cmd_issue;

  localparam int HOLD = 2;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  ddr3_cmd_issue_if bus ();

  ddr3_cmd_issue #(.P_HOLDOFF(HOLD)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  typedef struct {
    logic        rd;
    logic [4:0]  num;
    logic [15:0] prio;
    logic [26:0] addr;
    logic [11:0] len;
    bit          toggle;
    logic [31:0] exp_ack;
    int          exp_ncmd;
    logic [26:0] exp_a1;
    logic [2:0]  exp_cmd;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One transfer: request for one cycle (or held), track ack, commands and done.
  task automatic run_vec(input vec_t v, input bit keep_req);
    int          ncmd;
    int          acks;
    bit          done_seen;
    bit          held;
    logic [26:0] held_addr;
    logic [26:0] exp_addr;
    @(negedge clk);
    bus.i_ch_req        = 1'b1;
    bus.i_ch_num        = v.num;
    bus.i_ch_priority   = v.prio;
    bus.i_ch_rd_wrn     = v.rd;
    bus.i_ch_start_addr = v.addr;
    bus.i_ch_length     = v.len;
    bus.i_app_rdy       = 1'b1;
    @(posedge clk);
    ncmd = 0; acks = 0; done_seen = 1'b0; held = 1'b0;
    held_addr = '0; exp_addr = v.addr;
    for (int c = 1; c <= 9000 && !done_seen; c++) begin
      @(negedge clk);
      if (!keep_req) begin
        // Busy-time request and field changes must be ignored
        bus.i_ch_req        = (c % 3 == 0);
        bus.i_ch_num        = v.num ^ 5'h15;
        bus.i_ch_priority   = ~v.prio;
        bus.i_ch_rd_wrn     = ~v.rd;
        bus.i_ch_start_addr = ~v.addr;
        bus.i_ch_length     = 12'd0;
      end
      if (c == 1) begin
        chk("ack", bus.o_ch_ack, v.exp_ack);
        chk("busy_ack", {31'd0, bus.o_busy}, 32'd1);
        chk("en_in_ack", {31'd0, bus.o_app_en}, 32'd0);
        chk("prio", {16'd0, bus.o_cur_priority}, {16'd0, v.prio});
      end else if (bus.o_ch_ack != 32'd0) begin
        acks++;
      end
      if (held) begin
        chk("held_en", {31'd0, bus.o_app_en}, 32'd1);
        chk("held_addr", {5'd0, bus.o_app_addr}, {5'd0, held_addr});
        chk("held_cmd", {29'd0, bus.o_app_cmd}, {29'd0, v.exp_cmd});
        held = 1'b0;
      end
      if (c == 2) chk("first_en", {31'd0, bus.o_app_en}, (v.exp_ncmd > 0) ? 32'd1 : 32'd0);
      bus.i_app_rdy = v.toggle ? (c % 2 == 0) : 1'b1;
      if (bus.o_app_en) begin
        if (bus.i_app_rdy) begin
          if (ncmd == 1) chk("addr1", {5'd0, bus.o_app_addr}, {5'd0, v.exp_a1});
          else if (bus.o_app_addr !== exp_addr) chk("addr_seq", {5'd0, bus.o_app_addr}, {5'd0, exp_addr});
          if (bus.o_app_cmd !== v.exp_cmd) chk("cmd", {29'd0, bus.o_app_cmd}, {29'd0, v.exp_cmd});
          ncmd++;
          exp_addr = exp_addr + 27'd8;
        end else begin
          held = 1'b1;
          held_addr = bus.o_app_addr;
        end
      end
      if (bus.o_done) begin
        done_seen = 1'b1;
        chk("done_num", {27'd0, bus.o_done_num}, {27'd0, v.num});
        chk("ncmd", ncmd, v.exp_ncmd);
        if (v.exp_ncmd == 0) chk("done_lat", c, 32'd2);
      end
    end
    if (!done_seen) chk("done_timeout", 32'd0, 32'd1);
    chk("extra_ack", acks, 32'd0);
    bus.i_ch_req  = keep_req;
    bus.i_app_rdy = 1'b1;
    $display("[TB] ch %0d rd=%0d addr=0x%07h len=%0d: %0d cmds, done=%0d",
             v.num, v.rd, v.addr, v.len, ncmd, done_seen);
  endtask

  // After done with no request pending: HOLD cycles busy, then back to IDLE.
  task automatic hold_check();
    bus.i_ch_req = 1'b0;
    for (int k = 1; k <= HOLD; k++) begin
      @(negedge clk);
      chk("hold_busy", {31'd0, bus.o_busy}, 32'd1);
    end
    @(negedge clk);
    chk("idle_busy", {31'd0, bus.o_busy}, 32'd0);
  endtask

  initial begin
    int   gap;
    int   bad;
    bit   done2;
    vec_t hv;

    vecs[0] = '{1'b1, 5'd5,  16'h1234, 27'h0000100, 12'd16,   1'b0, 32'h00000020, 2,   27'h0000108, 3'b001};
    vecs[1] = '{1'b0, 5'd31, 16'hBEEF, 27'h0002000, 12'd9,    1'b1, 32'h80000000, 2,   27'h0002008, 3'b000};
    vecs[2] = '{1'b1, 5'd3,  16'h0001, 27'h0000040, 12'd0,    1'b0, 32'h00000008, 0,   27'h0000000, 3'b001};
    vecs[3] = '{1'b1, 5'd10, 16'h00FF, 27'h7FFFFF8, 12'd16,   1'b0, 32'h00000400, 2,   27'h0000000, 3'b001};
    vecs[4] = '{1'b0, 5'd0,  16'h8000, 27'h0000003, 12'd1,    1'b1, 32'h00000001, 1,   27'h0000000, 3'b000};
    vecs[5] = '{1'b1, 5'd17, 16'h5A5A, 27'h0000123, 12'd8,    1'b0, 32'h00020000, 1,   27'h0000000, 3'b001};
    vecs[6] = '{1'b0, 5'd20, 16'h0F0F, 27'h0000000, 12'd4095, 1'b0, 32'h00100000, 512, 27'h0000008, 3'b000};

    rst = 1'b1;
    bus.i_ch_req = 1'b0; bus.i_ch_num = '0; bus.i_ch_priority = '0;
    bus.i_ch_rd_wrn = 1'b0; bus.i_ch_start_addr = '0; bus.i_ch_length = '0;
    bus.i_app_rdy = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack",  bus.o_ch_ack, 32'd0);
    chk("rst_busy", {31'd0, bus.o_busy}, 32'd0);
    chk("rst_en",   {31'd0, bus.o_app_en}, 32'd0);
    chk("rst_cmd",  {29'd0, bus.o_app_cmd}, 32'd0);
    chk("rst_addr", {5'd0, bus.o_app_addr}, 32'd0);
    chk("rst_done", {26'd0, bus.o_done, bus.o_done_num}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i], 1'b0);
      hold_check();
    end

    // Request held high: the next ack must wait out the holdoff
    hv = '{1'b1, 5'd9, 16'h0042, 27'h0000800, 12'd8, 1'b0, 32'h00000200, 1, 27'h0, 3'b001};
    run_vec(hv, 1'b1);
    gap = 0;
    for (int k = 1; k <= 10 && gap == 0; k++) begin
      @(negedge clk);
      if (bus.o_ch_ack != 32'd0) gap = k;
    end
    chk("reack_gap", gap, HOLD + 2);
    chk("reack_val", bus.o_ch_ack, 32'h00000200);
    bus.i_ch_req = 1'b0;
    done2 = 1'b0;
    for (int k = 0; k < 20 && !done2; k++) begin
      @(negedge clk);
      if (bus.o_done) done2 = 1'b1;
    end
    chk("reack_done", {31'd0, done2}, 32'd1);
    hold_check();
    $display("[TB] held request: re-ack %0d cycles after done", gap);

    // Reset after the 2nd of 4 commands abandons the transfer
    @(negedge clk);
    bus.i_ch_req = 1'b1; bus.i_ch_num = 5'd7; bus.i_ch_priority = 16'h7777;
    bus.i_ch_rd_wrn = 1'b1; bus.i_ch_start_addr = 27'h0000500; bus.i_ch_length = 12'd32;
    bus.i_app_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk); bus.i_ch_req = 1'b0;   // ack cycle
    @(negedge clk);                        // 1st cmd
    @(negedge clk);                        // 2nd cmd
    @(negedge clk);                        // 3rd cmd pending
    chk("pre_rst_en",   {31'd0, bus.o_app_en}, 32'd1);
    chk("pre_rst_addr", {5'd0, bus.o_app_addr}, 32'h00000510);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ack",  bus.o_ch_ack, 32'd0);
    chk("mid_rst_busy", {31'd0, bus.o_busy}, 32'd0);
    chk("mid_rst_en",   {31'd0, bus.o_app_en}, 32'd0);
    chk("mid_rst_cmd",  {29'd0, bus.o_app_cmd}, 32'd0);
    chk("mid_rst_addr", {5'd0, bus.o_app_addr}, 32'd0);
    chk("mid_rst_done", {26'd0, bus.o_done, bus.o_done_num}, 32'd0);
    rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.o_app_en || bus.o_done || bus.o_busy) bad++;
    end
    chk("post_rst_quiet", bad, 32'd0);
    $display("[TB] reset mid-transfer: %0d active cycles afterwards", bad);
    run_vec(vecs[0], 1'b0);
    hold_check();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
